// File: rtl/i2c_sil9134_slave_model_pkg.sv
// Shared definitions for the SiI9134 I2C target model: state encoding, default
// device address, counter widths and the register-pointer increment.
package i2c_sil9134_slave_model_pkg;

  localparam logic [6:0] SIL_SLAVE_ID = 7'h39;
  localparam int         BYTE_W       = 8;
  localparam int         BIT_CNT_W    = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_REG_ADDR,
    ST_ACK_REG,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

  // Pointer wraps at the last implemented register, not only at 0xFF.
  function automatic logic [BYTE_W-1:0] ptr_inc(input logic [BYTE_W-1:0] ptr, input int depth);
    return (int'(ptr) >= depth - 1) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_sil9134_slave_model_bus_sync.sv
// Two-flop synchronisers for scl/sda plus single-clk edge, START and STOP pulses
// derived only from the synchronised copies.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] w_line_in;
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_prev;

  assign w_line_in = {i_scl, i_sda};

  // Lines reset to the idle-high level so release from reset creates no false edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_meta[gi] <= 1'b1;
          r_sync[gi] <= 1'b1;
          r_prev[gi] <= 1'b1;
        end else begin
          r_meta[gi] <= w_line_in[gi];
          r_sync[gi] <= r_meta[gi];
          r_prev[gi] <= r_sync[gi];
        end
      end
    end
  endgenerate

  assign o_sda      = r_sync[0];
  assign o_scl_rise =  r_sync[1] & ~r_prev[1];
  assign o_scl_fall = ~r_sync[1] &  r_prev[1];
  // START/STOP require scl stable high, so a coincident scl edge always wins.
  assign o_start    = r_sync[1] & r_prev[1] &  r_prev[0] & ~r_sync[0];
  assign o_stop     = r_sync[1] & r_prev[1] & ~r_prev[0] &  r_sync[0];

endmodule

// File: rtl/i2c_sil9134_slave_model.sv
// I2C target emulating the SiI9134 register file: byte writes through an 8-bit
// auto-incrementing pointer, sequential reads, open-drain sda.
module i2c_sil9134_slave_model
  import i2c_sil9134_slave_model_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID  = SIL_SLAVE_ID,
  parameter int         REG_DEPTH = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_scl,
  inout  wire               io_sda,
  output logic              o_reg_wr_en,
  output logic [BYTE_W-1:0] o_reg_wr_addr,
  output logic [BYTE_W-1:0] o_reg_wr_data,
  output logic              o_busy
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  state_t                r_state;
  state_t                w_state_next;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_byte_done;
  logic [BYTE_W-1:0]     r_shift;
  logic [BYTE_W-1:0]     r_ptr;
  logic [BYTE_W-1:0]     r_rd_data;
  logic                  r_mack;
  logic                  r_busy;
  logic                  r_wr_en;
  logic [BYTE_W-1:0]     r_wr_addr;
  logic [BYTE_W-1:0]     r_wr_data;
  logic [BYTE_W-1:0]     r_regs [REG_DEPTH];

  logic [BYTE_W-1:0]     w_rx_byte;
  logic                  w_last_bit;
  logic                  w_addr_match;
  logic                  w_rise_ev;
  logic                  w_fall_ev;
  logic                  w_wr_commit;
  logic                  w_rd_load;
  logic                  w_sda_oe;

  i2c_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i_scl),
    .i_sda      (io_sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_rx_byte    = {r_shift[BYTE_W-2:0], w_sda};
  assign w_last_bit   = (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  assign w_addr_match = (r_shift[BYTE_W-1:1] == SLAVE_ID);
  assign w_rise_ev    = w_scl_rise & ~w_start & ~w_stop;
  assign w_fall_ev    = w_scl_fall & ~w_start & ~w_stop;
  assign w_wr_commit  = w_rise_ev & (r_state == ST_WR_DATA) & w_last_bit;
  // The read shifter is reloaded at the scl fall that ends an ack slot.
  assign w_rd_load    = w_fall_ev & (((r_state == ST_ACK_DEV) & r_shift[0]) |
                                     ((r_state == ST_RD_ACK) & ~r_mack));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_stop) begin
      w_state_next = ST_IDLE;
    end else if (w_start) begin
      w_state_next = ST_DEV_ADDR;
    end else if (w_scl_fall) begin
      case (r_state)
        ST_DEV_ADDR: if (r_byte_done) w_state_next = w_addr_match ? ST_ACK_DEV : ST_WAIT_STOP;
        ST_ACK_DEV:  w_state_next = r_shift[0] ? ST_RD_DATA : ST_REG_ADDR;
        ST_REG_ADDR: if (r_byte_done) w_state_next = ST_ACK_REG;
        ST_ACK_REG:  w_state_next = ST_WR_DATA;
        ST_WR_DATA:  if (r_byte_done) w_state_next = ST_ACK_WR;
        ST_ACK_WR:   w_state_next = ST_WR_DATA;
        ST_RD_DATA:  if (r_byte_done) w_state_next = ST_RD_ACK;
        ST_RD_ACK:   w_state_next = r_mack ? ST_WAIT_STOP : ST_RD_DATA;
        default:     w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_sda_oe = 1'b0;
    case (r_state)
      ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: w_sda_oe = 1'b1;
      ST_RD_DATA:                        w_sda_oe = ~r_shift[BYTE_W-1];
      default:                           w_sda_oe = 1'b0;
    endcase
  end

  assign io_sda = w_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_mack      <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en <= w_wr_commit;
      if (w_start || w_stop) begin
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
        if (w_stop) r_busy <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA, ST_RD_DATA: begin
            r_bit_cnt   <= r_bit_cnt + 1'b1;
            r_byte_done <= w_last_bit;
            if (r_state != ST_RD_DATA) r_shift <= w_rx_byte;
            if (w_last_bit && r_state == ST_REG_ADDR) r_ptr <= w_rx_byte;
            if (w_wr_commit) begin
              r_wr_addr <= r_ptr;
              r_wr_data <= w_rx_byte;
              r_ptr     <= ptr_inc(r_ptr, REG_DEPTH);
            end
          end
          ST_RD_ACK: r_mack <= w_sda;
          default: ;
        endcase
      end else if (w_scl_fall) begin
        if (r_byte_done) begin
          r_byte_done <= 1'b0;
          r_bit_cnt   <= '0;
        end
        if (r_state == ST_DEV_ADDR && r_byte_done) r_busy <= w_addr_match;
        if (w_rd_load) begin
          r_shift <= r_rd_data;
          r_ptr   <= ptr_inc(r_ptr, REG_DEPTH);
        end else if (r_state == ST_RD_DATA && !r_byte_done) begin
          r_shift <= {r_shift[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  // Register file with a registered read port; the pointer is stable for many
  // clks before any read load, so r_rd_data is always current when used.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_commit) r_regs[r_ptr] <= w_rx_byte;
      r_rd_data <= r_regs[r_ptr];
    end
  end

  assign o_reg_wr_en   = r_wr_en;
  assign o_reg_wr_addr = r_wr_addr;
  assign o_reg_wr_data = r_wr_data;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_i2c_sil9134_slave_model.sv
// Directed bench: a bit-level I2C master drives the target model; committed
// register writes are checked against a queue of expected (addr, data) pairs.
`timescale 1ns/1ps
module tb_i2c_sil9134_slave_model;

  localparam int QCLK = 25;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       m_oe;
  wire        sda;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int dut_low_cnt = 0;
  int busy_cnt    = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_sil9134_slave_model dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_scl         (scl),
    .io_sda        (sda),
    .o_reg_wr_en   (wr_en),
    .o_reg_wr_addr (wr_addr),
    .o_reg_wr_data (wr_data),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: every reg_wr_en pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%02h data=%02h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          failures++;
          $display("FAIL wr_commit: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   wr_addr, wr_data, e.addr, e.data);
        end else begin
          $display("wr   addr=%02h data=%02h ok", wr_addr, wr_data);
        end
      end
    end
  end

  // Bus observer: counts clks where the target pulls sda low or asserts busy.
  always begin
    @(posedge clk);
    #2;
    if (!m_oe && sda === 1'b0) dut_low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic q();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; q(); scl = 1'b1; q(); m_oe = 1'b1; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; q(); scl = 1'b1; q(); m_oe = 1'b0; q(); q();
  endtask

  task automatic wbit(input logic b);
    m_oe = ~b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic rbit(output logic b);
    m_oe = 1'b0; q(); scl = 1'b1; q(); b = sda; q(); scl = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    ack = ~a;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~mack);
  endtask

  // Write n bytes from d (MSB byte first) starting at register a.
  task automatic wr_txn(input logic [7:0] a, input int n, input logic [23:0] d);
    logic       ack;
    logic [7:0] addr;
    addr = a;
    i2c_start();
    wbyte(8'h72, ack); chk("wr_id_ack", 32'(ack), 32'd1);
    wbyte(a, ack);     chk("wr_reg_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: addr, data: d[23-8*i -: 8]});
      wbyte(d[23-8*i -: 8], ack);
      chk("wr_data_ack", 32'(ack), 32'd1);
      addr = addr + 8'd1;
    end
    i2c_stop();
    chk("wr_busy_after_p", 32'(busy), 32'd0);
  endtask

  // Read n bytes from register a and compare with e (MSB byte first).
  task automatic rd_txn(input logic [7:0] a, input int n, input logic [23:0] e);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    wbyte(8'h72, ack); chk("rd_id_w_ack", 32'(ack), 32'd1);
    wbyte(a, ack);     chk("rd_reg_ack", 32'(ack), 32'd1);
    i2c_start();
    wbyte(8'h73, ack); chk("rd_id_r_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      rbyte(d, i != n - 1);
      $display("rd   addr=%02h data=%02h", a + 8'(i), d);
      chk("rd_data", 32'(d), 32'(e[23-8*i -: 8]));
    end
    chk("rd_sda_released", 32'(sda), 32'd1);
    i2c_stop();
    chk("rd_busy_after_p", 32'(busy), 32'd0);
  endtask

  initial begin
    logic ack;
    rst_n = 1'b0;
    scl   = 1'b1;
    m_oe  = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_wr_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);
    rst_n = 1'b1;
    q();

    // Single write 0x08 <- 0x35, with busy seen high after the address ack.
    i2c_start();
    wbyte(8'h72, ack); chk("t1_id_ack", 32'(ack), 32'd1);
    chk("t1_busy_high", 32'(busy), 32'd1);
    wbyte(8'h08, ack); chk("t1_reg_ack", 32'(ack), 32'd1);
    exp_q.push_back('{addr: 8'h08, data: 8'h35});
    wbyte(8'h35, ack); chk("t1_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    chk("t1_busy_after_p", 32'(busy), 32'd0);

    // Foreign address: NACK, sda never pulled by the target, busy never high.
    dut_low_cnt = 0;
    busy_cnt    = 0;
    i2c_start();
    wbyte(8'h74, ack); chk("t2_id_nack", 32'(ack), 32'd0);
    wbyte(8'h55, ack); chk("t2_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    chk("t2_sda_never_low", 32'(dut_low_cnt), 32'd0);
    chk("t2_busy_never", 32'(busy_cnt), 32'd0);

    // Burst with pointer wrap 0xFF -> 0x00.
    wr_txn(8'hFE, 3, 24'h112233);

    // Read-back of single write and of the wrapped burst.
    rd_txn(8'h08, 1, 24'h350000);
    rd_txn(8'hFE, 3, 24'h112233);

    // Partial data byte followed by STOP: nothing committed.
    i2c_start();
    wbyte(8'h72, ack); chk("t5_id_ack", 32'(ack), 32'd1);
    wbyte(8'h10, ack); chk("t5_reg_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    i2c_stop();
    chk("t5_busy_after_p", 32'(busy), 32'd0);
    rd_txn(8'h10, 1, 24'h000000);

    // Reset while the target drives a 0 read bit (0x35 MSB is 0).
    i2c_start();
    wbyte(8'h72, ack); chk("t6_id_ack", 32'(ack), 32'd1);
    wbyte(8'h08, ack); chk("t6_reg_ack", 32'(ack), 32'd1);
    i2c_start();
    wbyte(8'h73, ack); chk("t6_id_r_ack", 32'(ack), 32'd1);
    chk("t6_sda_driven_low", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_sda_released_async", 32'(sda), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    i2c_stop();
    wr_txn(8'h20, 1, 24'hA50000);
    rd_txn(8'h20, 1, 24'hA50000);
    rd_txn(8'h08, 1, 24'h000000);

    q();
    chk("wr_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
